// File: rtl/wait_checker.sv
// Scenario-bench observer: decodes CHK/WTR/WTF commands addressed by signal alias,
// checks levels or waits for edges on bit 0, and reports done/error pulses and an error count.
module wait_checker #(
    parameter int ARGS_NB    = 5,
    parameter int WAIT_SIZE  = 5,
    parameter int WAIT_WIDTH = 32,
    parameter int STR_W      = 128
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [WAIT_SIZE-1:0][STR_W-1:0]       i_wait_alias,
    input  logic [WAIT_SIZE-1:0][WAIT_WIDTH-1:0]  i_wait,
    input  logic                                  i_wait_sel,
    input  logic                                  i_args_valid,
    input  logic [ARGS_NB-1:0][STR_W-1:0]         i_args,
    output logic                                  o_busy,
    output logic                                  o_done,
    output logic                                  o_error,
    output logic [15:0]                           o_err_cnt
);

    localparam int IDX_W = (WAIT_SIZE > 1) ? $clog2(WAIT_SIZE) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Strings are ASCII packed right-justified, zero-padded on the left.
    localparam logic [STR_W-1:0] CMD_CHK = {{(STR_W-24){1'b0}}, "CHK"};
    localparam logic [STR_W-1:0] CMD_WTR = {{(STR_W-24){1'b0}}, "WTR"};
    localparam logic [STR_W-1:0] CMD_WTF = {{(STR_W-24){1'b0}}, "WTF"};

    function automatic logic [3:0] hex_digit(input logic [7:0] c);
        logic [7:0] d;
        if (c >= 8'h30 && c <= 8'h39) begin
            d = c - 8'h30;
        end else if (c >= 8'h61 && c <= 8'h66) begin
            d = c - 8'h57;
        end else if (c >= 8'h41 && c <= 8'h46) begin
            d = c - 8'h37;
        end else begin
            d = 8'h00;
        end
        return d[3:0];
    endfunction

    // A leading "0x" switches the remaining characters to hex; otherwise decimal.
    function automatic logic [63:0] parse_num(input logic [STR_W-1:0] s);
        logic [63:0] acc;
        logic        hex;
        logic [7:0]  c;
        logic [7:0]  first;
        int unsigned pos;
        acc   = 64'd0;
        hex   = 1'b0;
        first = 8'h00;
        pos   = 32'd0;
        for (int i = STR_W/8 - 1; i >= 0; i--) begin
            c = s[8*i +: 8];
            if (c != 8'h00) begin
                if (pos == 32'd1 && first == "0" && (c == "x" || c == "X")) begin
                    hex = 1'b1;
                    acc = 64'd0;
                end else if (hex) begin
                    acc = {acc[59:0], hex_digit(c)};
                end else begin
                    acc = acc * 64'd10 + {56'd0, c - 8'h30};
                end
                if (pos == 32'd0) begin
                    first = c;
                end else begin
                    first = first;
                end
                pos = pos + 32'd1;
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction

    logic [WAIT_SIZE-1:0][STR_W-1:0] alias_r;
    logic [1:0]                      state_r;
    logic [IDX_W-1:0]                idx_r;
    logic                            prev_r;
    logic [31:0]                     cnt_r;
    logic                            tmo_en_r;
    logic                            rise_r;
    logic                            fail_r;
    logic                            busy_r;
    logic                            done_r;
    logic                            error_r;
    logic                            drop_r;
    logic [15:0]                     err_cnt_r;

    logic                            hit_s;
    logic [IDX_W-1:0]                idx_s;
    logic [63:0]                     value_s;
    logic                            cmd_s;
    logic                            accept_s;
    logic                            drop_s;
    logic                            cur_s;
    logic                            edge_s;
    logic                            done_fail_s;
    logic [1:0]                      inc_s;
    logic [16:0]                     sum_s;
    logic [15:0]                     err_next_s;
    logic                            args_unused_s;

    assign value_s       = parse_num(i_args[2]);
    assign cmd_s         = i_wait_sel & i_args_valid;
    assign accept_s      = cmd_s & (state_r == ST_IDLE);
    assign drop_s        = cmd_s & (state_r != ST_IDLE);
    assign cur_s         = i_wait[idx_r][0];
    assign args_unused_s = ^{i_args, value_s};

    // Alias table is captured while reset is held and frozen afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            alias_r <= i_wait_alias;
        end
    end

    // Alias lookup; the lowest matching index wins.
    always_comb begin
        hit_s = 1'b0;
        idx_s = '0;
        for (int i = WAIT_SIZE - 1; i >= 0; i--) begin
            if (alias_r[i] == i_args[1]) begin
                hit_s = 1'b1;
                idx_s = IDX_W'(i);
            end else begin
                hit_s = hit_s;
            end
        end
    end

    // Edge qualification and saturating error-count update.
    always_comb begin
        edge_s      = rise_r ? (~prev_r & cur_s) : (prev_r & ~cur_s);
        done_fail_s = (state_r == ST_DONE) & fail_r;
        inc_s       = {1'b0, done_fail_s} + {1'b0, drop_r};
        sum_s       = {1'b0, err_cnt_r} + {15'd0, inc_s};
        if (sum_s[16]) begin
            err_next_s = 16'hFFFF;
        end else begin
            err_next_s = sum_s[15:0];
        end
    end

    // Command FSM and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            idx_r     <= '0;
            prev_r    <= 1'b0;
            cnt_r     <= 32'd0;
            tmo_en_r  <= 1'b0;
            rise_r    <= 1'b0;
            fail_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
            drop_r    <= 1'b0;
            err_cnt_r <= 16'd0;
        end else begin
            drop_r    <= drop_s;
            done_r    <= (state_r == ST_DONE);
            error_r   <= done_fail_s | drop_r;
            err_cnt_r <= err_next_s;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        if (i_args[0] == CMD_CHK) begin
                            state_r <= ST_DONE;
                            fail_r  <= ~(hit_s && (i_wait[idx_s] == value_s[WAIT_WIDTH-1:0]));
                        end else if ((i_args[0] == CMD_WTR || i_args[0] == CMD_WTF) && hit_s) begin
                            state_r  <= ST_WAIT;
                            busy_r   <= 1'b1;
                            idx_r    <= idx_s;
                            prev_r   <= i_wait[idx_s][0];
                            cnt_r    <= value_s[31:0];
                            tmo_en_r <= (value_s[31:0] != 32'd0);
                            rise_r   <= (i_args[0] == CMD_WTR);
                        end else begin
                            state_r <= ST_DONE;
                            fail_r  <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    prev_r <= cur_s;
                    if (edge_s) begin
                        state_r <= ST_DONE;
                        fail_r  <= 1'b0;
                        busy_r  <= 1'b0;
                    end else if (tmo_en_r) begin
                        cnt_r <= cnt_r - 32'd1;
                        if (cnt_r == 32'd1) begin
                            state_r <= ST_DONE;
                            fail_r  <= 1'b1;
                            busy_r  <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy    = busy_r;
    assign o_done    = done_r;
    assign o_error   = error_r;
    assign o_err_cnt = err_cnt_r;

endmodule

// File: tb/tb_wait_checker.sv
// Directed bench for wait_checker: stimulus pushes expected done/error events into a
// queue, and a negedge monitor pops and compares them whenever the DUT reports.
module tb_wait_checker;

    localparam int ARGS_NB    = 5;
    localparam int WAIT_SIZE  = 5;
    localparam int WAIT_WIDTH = 32;
    localparam int STR_W      = 128;

    typedef struct {
        int cyc;
        bit done;
        bit err;
        int cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [WAIT_SIZE-1:0][STR_W-1:0]      wait_alias;
    logic [WAIT_SIZE-1:0][WAIT_WIDTH-1:0] wait_sig;
    logic                                 wait_sel = 1'b0;
    logic                                 args_valid = 1'b0;
    logic [ARGS_NB-1:0][STR_W-1:0]        args = '0;
    logic                                 busy;
    logic                                 done;
    logic                                 error;
    logic [15:0]                          err_cnt;
    logic                                 irq = 1'b0;
    logic                                 rdy = 1'b0;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign wait_sig = {32'd0, 32'd0, {31'd0, rdy}, {31'd0, irq}, 32'h0000_00A5};

    wait_checker #(
        .ARGS_NB(ARGS_NB), .WAIT_SIZE(WAIT_SIZE), .WAIT_WIDTH(WAIT_WIDTH), .STR_W(STR_W)
    ) dut (
        .clk(clk), .rst(rst),
        .i_wait_alias(wait_alias), .i_wait(wait_sig),
        .i_wait_sel(wait_sel), .i_args_valid(args_valid), .i_args(args),
        .o_busy(busy), .o_done(done), .o_error(error), .o_err_cnt(err_cnt)
    );

    function automatic void check(input string name, input longint act, input longint req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual %0d, required %0d", name, act, req);
        end
    endfunction

    function automatic logic [STR_W-1:0] s2p(input string s);
        logic [STR_W-1:0] r;
        r = '0;
        for (int i = 0; i < s.len(); i++) r = {r[STR_W-9:0], s[i]};
        return r;
    endfunction

    function automatic void expect_ev(input int c, input bit d, input bit e, input int n);
        exp_t x;
        x.cyc = c; x.done = d; x.err = e; x.cnt = n;
        q.push_back(x);
    endfunction

    // Drives one command for one clock; t is the index of the accepting edge.
    task automatic issue(input string c, input string a, input string v, output int t);
        @(negedge clk);
        args       = '0;
        args[0]    = s2p(c);
        args[1]    = s2p(a);
        args[2]    = s2p(v);
        wait_sel   = 1'b1;
        args_valid = 1'b1;
        @(posedge clk);
        #1;
        t          = cyc;
        wait_sel   = 1'b0;
        args_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (q.size() == 0) break;
            @(posedge clk);
        end
        if (q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: actual %0d pending events, required 0", q.size());
            q.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    // Monitor: every done/error pulse must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && (done || error)) begin
            if (q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_event: actual done=%0b error=%0b at cycle %0d, required no event",
                         done, error, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("event_cycle", cyc, e.cyc);
                check("event_done", done, e.done);
                check("event_error", error, e.err);
                check("event_err_cnt", err_cnt, e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual time limit hit, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int t2;
        int x;
        wait_alias[0] = s2p("DATA");
        wait_alias[1] = s2p("IRQ");
        wait_alias[2] = s2p("RDY");
        wait_alias[3] = s2p("BUS");
        wait_alias[4] = s2p("ACK");
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_error", error, 0);
        check("reset_err_cnt", err_cnt, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Level checks: hex, decimal, mismatch.
        issue("CHK", "DATA", "0xA5", t); expect_ev(t + 1, 1, 0, 0); drain();
        issue("CHK", "DATA", "165", t);  expect_ev(t + 1, 1, 0, 0); drain();
        issue("CHK", "DATA", "0xA4", t); expect_ev(t + 1, 1, 1, 1); drain();

        // Back-to-back: second command accepted at the edge ending the first o_done cycle.
        issue("CHK", "DATA", "0xa5", t); expect_ev(t + 1, 1, 0, 1);
        @(posedge clk);
        issue("CHK", "DATA", "0x000000A5", t2); expect_ev(t2 + 1, 1, 0, 1);
        check("back_to_back_edge", t2, t + 2);
        drain();

        // Rising edge sampled at t+10.
        issue("WTR", "IRQ", "100", t);
        expect_ev(t + 11, 1, 0, 1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("wtr_busy_mid", busy, 1);
        repeat (5) @(negedge clk);
        irq = 1'b1;
        @(negedge clk);
        check("wtr_busy_after_edge", busy, 0);
        drain();

        // Falling-edge timeout with RDY held high.
        rdy = 1'b1;
        @(posedge clk);
        issue("WTF", "RDY", "20", t);
        expect_ev(t + 21, 1, 1, 2);
        @(negedge clk);
        check("wtf_busy_mid", busy, 1);
        drain();
        check("wtf_busy_after", busy, 0);

        // Unknown alias, unknown command.
        issue("CHK", "FOO", "1", t); expect_ev(t + 1, 1, 1, 3); drain();
        issue("XYZ", "DATA", "0", t); expect_ev(t + 1, 1, 1, 4); drain();

        // Overlap: a command during a forever wait is dropped with a lone error.
        irq = 1'b0;
        repeat (2) @(posedge clk);
        issue("WTR", "IRQ", "0", t);
        issue("CHK", "DATA", "0xA5", x);
        expect_ev(x + 1, 0, 1, 5);
        drain();
        @(negedge clk);
        check("overlap_busy_kept", busy, 1);
        irq = 1'b1;
        expect_ev(cyc + 2, 1, 0, 5);
        drain();
        check("overlap_busy_after", busy, 0);

        // Asynchronous reset during a wait.
        irq = 1'b0;
        repeat (2) @(posedge clk);
        issue("WTR", "IRQ", "50", t);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        check("midreset_error", error, 0);
        check("midreset_err_cnt", err_cnt, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        issue("CHK", "DATA", "0xA5", t); expect_ev(t + 1, 1, 0, 0); drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wait_checker.md
# wait_checker

Testbench-side observer that turns scenario command arguments into checks and waits on DUT signals. Each observed signal is addressed by a string alias. The block supports three commands: CHK compares a level, WTR waits for a rising edge with a timeout, and WTF waits for a falling edge with a timeout. It sits beside the signal injector in the scenario bench: the injector drives DUT inputs, this block reads DUT outputs and reports completion and errors back to the scenario sequencer.

## Interface
- ARGS_NB, 5, number of string arguments per command line
- WAIT_SIZE, 5, number of observed signals
- WAIT_WIDTH, 32, bit width of each observed signal
- clk  in  1  bench clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- i_wait_alias  in  string[WAIT_SIZE]  alias of each observed signal; index = position
- i_wait  in  [WAIT_WIDTH-1:0][WAIT_SIZE]  observed DUT signals
- i_wait_sel  in  1  command belongs to this block
- i_args_valid  in  1  i_args holds a command this cycle
- i_args  in  string[ARGS_NB]  [0]=command, [1]=alias, [2]=value or timeout
- o_busy  out  1  a WTR/WTF wait is in progress
- o_done  out  1  one-cycle pulse: command finished, pass or fail
- o_error  out  1  one-cycle pulse: command failed
- o_err_cnt  out  16  saturating count of failed commands

## Operation
- Alias map: while rst is high, load an associative table alias→index from i_wait_alias. The map is stable after reset release.
- Argument decode for i_args[2]:
  - Leading "0x": the remainder is parsed as hex.
  - Otherwise: parsed as decimal. Values are truncated to WAIT_WIDTH for CHK and to 32 bits for timeout.
- A command is accepted only when i_wait_sel, i_args_valid and state IDLE are all true.
- FSM states:
  - IDLE: on an accepted command, decode i_args[0].
    - "CHK": compare i_wait[idx] to the value, go to DONE. Fail if they are unequal.
    - "WTR"/"WTF": capture prev = i_wait[idx][0], load cnt = timeout, go to WAIT.
    - Any other string, or an alias missing from the map: go to DONE with fail.
  - WAIT: o_busy=1. Each cycle, compare cur = i_wait[idx][0] against prev, then set prev = cur.
    - Edge seen: WTR needs prev=0,cur=1; WTF needs prev=1,cur=0. Go to DONE with pass.
    - Otherwise, if timeout≠0: decrement cnt. When cnt reaches 0, go to DONE with fail.
    - Timeout 0 means wait forever.
  - DONE: assert o_done for one cycle. Assert o_error the same cycle if fail. Increment o_err_cnt if fail, saturating at 16'hFFFF. Return to IDLE.
- Edge detection uses bit 0 of the selected signal only.
- Command received while not IDLE: dropped. In the next cycle, o_error pulses alone with o_done=0, and o_err_cnt increments. The current wait is unaffected.
- Command with i_wait_sel=0: ignored, no effect.
- Reset mid-wait: returns to IDLE immediately with all outputs 0. No o_done is produced for the aborted command.

## Timing
- Reset values: o_busy=0, o_done=0, o_error=0, o_err_cnt=0. FSM is in IDLE, cnt=0, prev=0.
- CHK accepted at edge T: compare uses i_wait sampled at T. o_done (and o_error if fail) is high in cycle T+1 to T+2.
- WTR/WTF accepted at edge T: o_busy rises after T. Edges are sampled from T+1 onward.
  - Edge seen at sample edge E: o_busy falls after E, and o_done is high for the cycle after E.
- Timeout N accepted at T with no edge: the last sample is at T+N. o_done and o_error are high in the cycle after T+N.
- An edge coinciding with the final timeout sample counts as pass.
- Back-to-back: the next command is accepted no earlier than the cycle in which o_done is high. The FSM is IDLE again at that edge.

## Test plan
- CHK pass/fail:
  - Stimulus: alias "DATA"=32'h0000_00A5; CHK DATA 0xA5.
  - Required: o_done pulse, o_error=0, o_err_cnt=0.
  - Then CHK DATA 165: pass.
  - Then CHK DATA 0xA4: o_done and o_error pulse together, o_err_cnt=1.
- WTR success:
  - Stimulus: "IRQ"=0; WTR IRQ 100; raise IRQ 10 cycles later.
  - Required: o_busy high ~10 cycles, o_done exactly one cycle after the rising sample, o_error=0.
- WTF timeout:
  - Stimulus: "RDY"=1 held; WTF RDY 20.
  - Required: o_done and o_error in cycle T+21, o_err_cnt increments, o_busy=0 afterwards.
- Bad inputs:
  - Unknown alias "FOO", then unknown command "XYZ".
  - Required: each gives o_done+o_error one cycle later; o_err_cnt +2.
- Overlap:
  - Stimulus: WTR IRQ 0 in progress; issue CHK DATA 0xA5.
  - Required: lone o_error pulse, o_err_cnt +1, wait continues.
  - Then raise IRQ: done with pass.
- Reset mid-wait:
  - Stimulus: assert rst asynchronously during WTR.
  - Required: o_busy drops immediately, o_err_cnt=0, no o_done. After release, CHK works normally.
